imem_boot_controller: RTL and testbench

//  Owns the 1024x32 instruction memory's address/write port: streams a program into it after reset,

---
 rtl/imem_boot_controller.sv | 170 +++++++++++++++++
 tb/tb_imem_boot_controller.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_controller.sv
// Boot loader and fetch arbiter for a 1024x32 instruction memory: streams a program in, then hands reads to the CPU.
// Optional IMEM_CHECKSUM_EN: the ld_last beat carries an XOR checksum of the written words instead of data.
module imem_boot_controller #(
    parameter int          ADDR_W   = 10,
    parameter int          DEPTH    = 1 << ADDR_W,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic [31:0]       cpu_pc,
    output logic [31:0]       cpu_instr,
    output logic              cpu_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   word_count,
    output logic [1:0]        state_dbg
);

    // Encoding is visible on state_dbg: IDLE=0, LOAD=1, RUN=2, ERROR=3.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W + 1)'(1);

    state_t          state_q, state_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic beat;
    logic wr;
    logic misaligned;
    logic unused_pc_bits;

    // Handshake: a beat transfers on any cycle where ld_valid && ld_ready; ld_ready is high only in LOAD.
    assign beat       = (state_q == S_LOAD) && ld_valid;
    assign misaligned = (state_q == S_RUN) && (cpu_pc[1:0] != 2'b00);
    assign unused_pc_bits = ^cpu_pc[31:ADDR_W+2];

`ifdef IMEM_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;

    assign wr = beat && !ld_last;
`else
    assign wr = beat;
`endif

    always_comb begin
        ld_ready  = (state_q == S_LOAD);
        cpu_stall = (state_q != S_RUN);
        mem_we    = wr;
        mem_wd    = ld_data;
        mem_addr  = count_q[ADDR_W-1:0];
        cpu_instr = NOP_WORD;
        if (state_q == S_RUN) begin
            mem_addr = cpu_pc[ADDR_W+1:2];
            if (!misaligned) begin
                cpu_instr = mem_rd;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = done_q;
        err_d   = err_q;
`ifdef IMEM_CHECKSUM_EN
        csum_d  = csum_q;
`endif

        if (wr) begin
            if (count_q != FULL_CNT) begin
                count_d = count_q + ONE_CNT;
            end
`ifdef IMEM_CHECKSUM_EN
            csum_d = csum_q ^ ld_data;
`endif
        end

        case (state_q)
            S_LOAD: begin
                if (beat) begin
                    if (ld_last) begin
`ifdef IMEM_CHECKSUM_EN
                        if (ld_data == csum_q) begin
                            state_d = S_RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_ERROR;
                            err_d   = 1'b1;
                            done_d  = 1'b0;
                        end
`else
                        state_d = S_RUN;
                        done_d  = 1'b1;
`endif
                    end else if (count_q == LAST_IDX) begin
                        // Memory is full and the stream has not ended: overflow.
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                        done_d  = 1'b0;
                    end
                end
            end
            S_RUN: begin
                if (misaligned) begin
                    err_d = 1'b1;
                end
            end
            S_ERROR: begin
                err_d  = 1'b1;
                done_d = 1'b0;
            end
            default: ;
        endcase

        // Restart wins over everything except the write already presented this cycle.
        if (load_start) begin
            state_d = S_LOAD;
            count_d = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
`ifdef IMEM_CHECKSUM_EN
            csum_d  = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef IMEM_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign load_done  = done_q;
    assign load_error = err_q;
    assign word_count = count_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_imem_boot_controller.sv
// Directed bench for imem_boot_controller with a behavioural 1024x32 instruction memory attached.
module tb_imem_boot_controller;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_ERROR = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic [31:0] cpu_pc;
    logic [31:0] cpu_instr;
    logic        cpu_stall;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        load_done;
    logic        load_error;
    logic [10:0] word_count;
    logic [1:0]  state_dbg;

    logic [31:0] mem [0:1023];

    int n_cmp = 0;
    int n_err = 0;

    imem_boot_controller dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .cpu_pc     (cpu_pc),
        .cpu_instr  (cpu_instr),
        .cpu_stall  (cpu_stall),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd),
        .load_done  (load_done),
        .load_error (load_error),
        .word_count (word_count),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wd;
    end
    assign mem_rd = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rst        = 1'b1;
        load_start = 1'b0;
        ld_valid   = 1'b0;
        ld_data    = 32'h0;
        ld_last    = 1'b0;
        cpu_pc     = 32'h0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        chk("rst_wc", 32'(word_count), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd1);
        chk("rst_ready", 32'(ld_ready), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_error), 32'd0);
        chk("rst_instr", cpu_instr, 32'h0);
        rst = 1'b0;
        step();

        // 1: reset mid-LOAD after three beats
        pulse_start();
        chk("t1_state_load", 32'(state_dbg), 32'(ST_LOAD));
        chk("t1_ready", 32'(ld_ready), 32'd1);
        beat(32'h0000_0011, 1'b0);
        beat(32'h0000_0022, 1'b0);
        beat(32'h0000_0033, 1'b0);
        chk("t1_wc3", 32'(word_count), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("t1_rst_state", 32'(state_dbg), 32'(ST_IDLE));
        chk("t1_rst_wc", 32'(word_count), 32'd0);
        chk("t1_rst_stall", 32'(cpu_stall), 32'd1);
        chk("t1_rst_ready", 32'(ld_ready), 32'd0);
        chk("t1_rst_done", 32'(load_done), 32'd0);
        step();
        rst = 1'b0;
        step();

`ifndef IMEM_CHECKSUM_EN
        // 2: three-word program, fetch word 2
        pulse_start();
        beat(32'h2008_0005, 1'b0);
        beat(32'h2009_0003, 1'b0);
        ld_valid = 1'b1;
        ld_data  = 32'h0109_5020;
        ld_last  = 1'b1;
        #1;
        chk("t2_we", 32'(mem_we), 32'd1);
        chk("t2_addr", 32'(mem_addr), 32'd2);
        chk("t2_wd", mem_wd, 32'h0109_5020);
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("t2_state_run", 32'(state_dbg), 32'(ST_RUN));
        chk("t2_wc", 32'(word_count), 32'd3);
        chk("t2_done", 32'(load_done), 32'd1);
        chk("t2_stall", 32'(cpu_stall), 32'd0);
        chk("t2_mem0", mem[0], 32'h2008_0005);
        chk("t2_mem1", mem[1], 32'h2009_0003);
        chk("t2_mem2", mem[2], 32'h0109_5020);
        cpu_pc = 32'h8;
        #1;
        chk("t2_instr_pc8", cpu_instr, 32'h0109_5020);
        cpu_pc = 32'h0;
        #1;
        chk("t2_instr_pc0", cpu_instr, 32'h2008_0005);

        // 3: gapped stream
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b0;
            #1;
            chk("t3_gap_we", 32'(mem_we), 32'd0);
            step();
            ld_valid = 1'b1;
            ld_data  = 32'hC0DE_0000 + 32'(i);
            ld_last  = (i == 2);
            #1;
            chk("t3_we", 32'(mem_we), 32'd1);
            chk("t3_addr", 32'(mem_addr), 32'(i));
            step();
            ld_valid = 1'b0;
            ld_last  = 1'b0;
        end
        chk("t3_state_run", 32'(state_dbg), 32'(ST_RUN));
        chk("t3_wc", 32'(word_count), 32'd3);
        chk("t3_mem1", mem[1], 32'hC0DE_0001);
        chk("t3_mem2", mem[2], 32'hC0DE_0002);

        // 5: reload from RUN, then misaligned fetch
        pulse_start();
        chk("t5_stall", 32'(cpu_stall), 32'd1);
        chk("t5_state_load", 32'(state_dbg), 32'(ST_LOAD));
        chk("t5_done_clr", 32'(load_done), 32'd0);
        chk("t5_wc_clr", 32'(word_count), 32'd0);
        beat(32'hDEAD_BEEF, 1'b1);
        chk("t5_mem0", mem[0], 32'hDEAD_BEEF);
        chk("t5_state_run", 32'(state_dbg), 32'(ST_RUN));
        cpu_pc = 32'h2;
        #1;
        chk("t5_misalign_instr", cpu_instr, 32'h0);
        step();
        chk("t5_err", 32'(load_error), 32'd1);
        chk("t5_still_run", 32'(state_dbg), 32'(ST_RUN));
        cpu_pc = 32'h0;
        #1;
        chk("t5_aligned_instr", cpu_instr, 32'hDEAD_BEEF);
        chk("t5_err_sticky", 32'(load_error), 32'd1);
`endif

        // load_start together with a beat: beat is written, then the load restarts
        pulse_start();
        chk("pri_err_clr", 32'(load_error), 32'd0);
        beat(32'h0000_0001, 1'b0);
        load_start = 1'b1;
        ld_valid   = 1'b1;
        ld_data    = 32'h0000_0055;
        ld_last    = 1'b0;
        #1;
        chk("pri_we", 32'(mem_we), 32'd1);
        chk("pri_addr", 32'(mem_addr), 32'd1);
        step();
        load_start = 1'b0;
        ld_valid   = 1'b0;
        chk("pri_mem1", mem[1], 32'h0000_0055);
        chk("pri_wc", 32'(word_count), 32'd0);
        chk("pri_state", 32'(state_dbg), 32'(ST_LOAD));

        // 4: overflow with 1024 beats and no ld_last
        for (int i = 0; i < 1023; i++) beat(32'h5A5A_0000 ^ 32'(i), 1'b0);
        chk("t4_wc1023", 32'(word_count), 32'd1023);
        ld_valid = 1'b1;
        ld_data  = 32'h5A5A_03FF;
        #1;
        chk("t4_we_last", 32'(mem_we), 32'd1);
        chk("t4_addr_last", 32'(mem_addr), 32'h3FF);
        step();
        ld_valid = 1'b0;
        chk("t4_mem3ff", mem[1023], 32'h5A5A_03FF);
        chk("t4_state_err", 32'(state_dbg), 32'(ST_ERROR));
        chk("t4_err", 32'(load_error), 32'd1);
        chk("t4_stall", 32'(cpu_stall), 32'd1);
        chk("t4_done", 32'(load_done), 32'd0);
        chk("t4_wc_sat", 32'(word_count), 32'd1024);
        chk("t4_ready", 32'(ld_ready), 32'd0);
        ld_valid = 1'b1;
        #1;
        chk("t4_no_we_in_err", 32'(mem_we), 32'd0);
        chk("t4_addr_err", 32'(mem_addr), 32'd0);
        step();
        ld_valid = 1'b0;
        chk("t4_wc_hold", 32'(word_count), 32'd1024);

`ifdef IMEM_CHECKSUM_EN
        // 6: checksum match, mismatch, checksum-only stream
        pulse_start();
        beat(32'hA5A5_A5A5, 1'b0);
        beat(32'h0F0F_0F0F, 1'b0);
        ld_valid = 1'b1;
        ld_data  = 32'hAAAA_AAAA;
        ld_last  = 1'b1;
        #1;
        chk("t6_csum_no_we", 32'(mem_we), 32'd0);
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("t6_state_run", 32'(state_dbg), 32'(ST_RUN));
        chk("t6_wc2", 32'(word_count), 32'd2);
        chk("t6_done", 32'(load_done), 32'd1);
        chk("t6_mem2_untouched", mem[2], 32'h5A5A_0002);
        pulse_start();
        beat(32'hA5A5_A5A5, 1'b0);
        beat(32'h0F0F_0F0F, 1'b0);
        beat(32'h0000_0001, 1'b1);
        chk("t6_state_err", 32'(state_dbg), 32'(ST_ERROR));
        chk("t6_err", 32'(load_error), 32'd1);
        chk("t6_done_clr", 32'(load_done), 32'd0);
        pulse_start();
        beat(32'h0000_0000, 1'b1);
        chk("t6_only_state", 32'(state_dbg), 32'(ST_RUN));
        chk("t6_only_wc", 32'(word_count), 32'd0);
`else
        pulse_start();
        chk("reload_from_err_state", 32'(state_dbg), 32'(ST_LOAD));
        chk("reload_from_err_clr", 32'(load_error), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
